rcb_frl_msg_arbiter: RTL



---
 rtl/rcb_frl_msg_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rcb_frl_msg_arbiter.sv
// ============================================================================
// Module  : rcb_frl_msg_arbiter
// Brief   : Write-side scheduler for the 40-bit FRL message FIFO. Optional
//           stall counter is enabled with the RCB_FRL_MSG_STALL_CNT_EN macro.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rcb_frl_msg_arbiter #(
    parameter int MAX_BURST = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [3:0]   REQ_VALID,
    input  logic [3:0]   REQ_LAST,
    input  logic [127:0] REQ_DATA,
    output logic [3:0]   REQ_READY,
    input  logic         FIFO_FULL,
    input  logic         FIFO_ALMOSTFULL,
    output logic         FIFO_WREN,
    output logic [39:0]  FIFO_DI,
    output logic [1:0]   GRANT_IDX,
    output logic         BUSY
`ifdef RCB_FRL_MSG_STALL_CNT_EN
    ,
    output logic [15:0]  STALL_CNT
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_rr_ptr;
    logic [1:0]  r_lock;
    logic [3:0]  r_seq;
    logic [7:0]  r_cnt;
    logic [1:0]  r_grant;

    logic        w_rr_found;
    logic [1:0]  w_rr_win;
    logic [3:0]  w_ready;
    logic [1:0]  w_src;
    logic        w_sop;
    logic        w_eop;
    logic        w_wren;
    logic [7:0]  w_word_idx;
    logic [31:0] w_payload;

    // Round-robin search: first valid source at or above r_rr_ptr, mod 4.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_win   = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] v_idx;
            v_idx = r_rr_ptr + 2'(k);
            if (!w_rr_found && REQ_VALID[v_idx]) begin
                w_rr_found = 1'b1;
                w_rr_win   = v_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 4'b0000;
        w_src       = r_lock;
        w_sop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!FIFO_FULL && !FIFO_ALMOSTFULL && w_rr_found) begin
                    w_ready = 4'b0001 << w_rr_win;
                    w_src   = w_rr_win;
                    w_sop   = 1'b1;
                end
            end
            ST_BURST: begin
                // Almost-full is deliberately ignored so an open burst can finish.
                if (!FIFO_FULL && REQ_VALID[r_lock]) begin
                    w_ready = 4'b0001 << r_lock;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_wren     = |w_ready;
        w_word_idx = w_sop ? 8'd1 : r_cnt + 8'd1;
        w_eop      = REQ_LAST[w_src] | (w_word_idx == C_MAX_BURST);
        w_payload  = REQ_DATA[{w_src, 5'd0} +: 32];

        if (w_wren) begin
            w_state_nxt = w_eop ? ST_IDLE : ST_BURST;
        end
    end

    // Combinational outputs are forced to their reset values while RST is high.
    assign REQ_READY = RST ? 4'b0000 : w_ready;
    assign FIFO_WREN = RST ? 1'b0 : w_wren;
    assign FIFO_DI   = (RST || !w_wren) ? 40'd0
                                        : {w_src, w_sop, w_eop, r_seq, w_payload};
    assign GRANT_IDX = r_grant;
    assign BUSY      = (r_state == ST_BURST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= 2'd0;
            r_lock   <= 2'd0;
            r_seq    <= 4'd0;
            r_cnt    <= 8'd0;
            r_grant  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wren) begin
                r_grant <= w_src;
                if (w_sop) begin
                    r_lock <= w_src;
                end
                if (w_eop) begin
                    r_seq    <= r_seq + 4'd1;
                    r_rr_ptr <= w_src + 2'd1;
                    r_cnt    <= 8'd0;
                end else begin
                    r_cnt <= w_word_idx;
                end
            end
        end
    end

`ifdef RCB_FRL_MSG_STALL_CNT_EN
    logic [15:0] r_stall;
    logic        w_stall_evt;

    assign w_stall_evt = (|REQ_VALID) && !w_wren &&
                         (FIFO_FULL || ((r_state == ST_IDLE) && FIFO_ALMOSTFULL));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall <= 16'd0;
        end else if (w_stall_evt && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign STALL_CNT = r_stall;
`endif

endmodule

`default_nettype wire
